// File: rtl/nios_system_spi_pkg.sv
// Shared types and constants for the Nios SPI engine: FSM states, register
// addresses and STATUS/CONTROL bit positions.
package nios_system_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  localparam logic [1:0] ADDR_TX     = 2'd0;
  localparam logic [1:0] ADDR_RX     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_ABORT    = 3;

  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_LOOPBACK = 1;

endpackage

// File: rtl/nios_system_spi_engine_if.sv
// Avalon-MM slave bus bundle for the SPI engine register file.
interface nios_system_spi_engine_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_system_spi_clkgen.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV clocks while enabled,
// with rise=1 when that tick is an odd-numbered (rising SCLK) strobe.
module nios_system_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick,
    output logic rise
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          phase;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = phase;

    // Dropping enable restarts both count and phase so every transfer begins aligned.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nios_system_spi_engine.sv
// Avalon-MM SPI master, mode 0, MSB first, gated by the chip-select PIO.
// Build option: define SPI_ENGINE_LOOPBACK_EN to enable CONTROL.loopback.
module nios_system_spi_engine
    import nios_system_spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    nios_system_spi_engine_if.slave   avs,
    input  logic                      cs_select,
    output logic                      irq,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      spi_ss_n
);

    localparam int HC_W = (2 * DATA_W > 2) ? $clog2(2 * DATA_W) : 1;

    spi_state_e state_q, state_d;

    logic [DATA_W-1:0] shifter;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] rxdata;
    logic [HC_W-1:0]   hcnt;
    logic              miso_bit;
    logic              sample_src;
    logic              rx_valid, overrun, abort_err, irq_en;
    logic              tick, rise, last_half;
    logic              accept, reject, abort, done;
    logic              wr, rd, tx_wr, rx_rd, st_wr, ctrl_wr;
    logic [31:0]       rdata;
    logic              unused_wdata;

    assign wr      = avs.chipselect & ~avs.write_n;
    assign rd      = avs.chipselect & ~avs.read_n;
    assign tx_wr   = wr && (avs.address == ADDR_TX);
    assign st_wr   = wr && (avs.address == ADDR_STATUS);
    assign ctrl_wr = wr && (avs.address == ADDR_CTRL);
    assign rx_rd   = rd && (avs.address == ADDR_RX);

    assign unused_wdata = ^avs.writedata;

    assign last_half  = (hcnt == HC_W'(2 * DATA_W - 1));
    assign shift_next = DATA_W'({shifter, miso_bit});

`ifdef SPI_ENGINE_LOOPBACK_EN
    logic loopback;
    assign sample_src = loopback ? spi_mosi : spi_miso;
`else
    assign sample_src = spi_miso;
`endif

    nios_system_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != IDLE),
        .tick  (tick),
        .rise  (rise)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        abort   = 1'b0;
        done    = 1'b0;
        if (state_q != IDLE && !cs_select) begin
            abort   = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tx_wr) begin
                        if (cs_select) begin
                            accept  = 1'b1;
                            state_d = LEAD;
                        end else begin
                            reject  = 1'b1;
                        end
                    end
                end
                LEAD:  if (tick) state_d = SHIFT;
                SHIFT: if (tick && last_half) state_d = TRAIL;
                TRAIL: begin
                    if (tick) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; later assignments in the block take priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_ss_n  <= 1'b1;
            irq       <= 1'b0;
            shifter   <= '0;
            rxdata    <= '0;
            hcnt      <= '0;
            miso_bit  <= 1'b0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            abort_err <= 1'b0;
            irq_en    <= 1'b0;
`ifdef SPI_ENGINE_LOOPBACK_EN
            loopback  <= 1'b0;
`endif
        end else begin
            spi_ss_n <= ~cs_select;
            irq      <= irq_en & (rx_valid | abort_err);

            if (abort) begin
                spi_sclk <= 1'b0;
                spi_mosi <= 1'b0;
                hcnt     <= '0;
            end else if (accept) begin
                shifter  <= avs.writedata[DATA_W-1:0];
                spi_mosi <= avs.writedata[DATA_W-1];
                spi_sclk <= 1'b0;
                hcnt     <= '0;
            end else if (state_q == SHIFT && tick) begin
                hcnt <= hcnt + HC_W'(1);
                if (rise) begin
                    spi_sclk <= 1'b1;
                    miso_bit <= sample_src;
                end else begin
                    spi_sclk <= 1'b0;
                    shifter  <= shift_next;
                    // After the final fall there is no next bit; park the line low.
                    spi_mosi <= last_half ? 1'b0 : shift_next[DATA_W-1];
                end
            end

            if (st_wr && avs.writedata[STAT_OVERRUN]) overrun   <= 1'b0;
            if (st_wr && avs.writedata[STAT_ABORT])   abort_err <= 1'b0;
            if (abort || reject)                      abort_err <= 1'b1;

            // A read landing on the completion cycle consumes the old frame, not the new one.
            if (done) begin
                rxdata   <= shifter;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_rd) overrun <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end

            if (ctrl_wr) begin
                irq_en   <= avs.writedata[CTRL_IRQ_EN];
`ifdef SPI_ENGINE_LOOPBACK_EN
                loopback <= avs.writedata[CTRL_LOOPBACK];
`endif
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (avs.address)
            ADDR_RX: rdata[DATA_W-1:0] = rxdata;
            ADDR_STATUS: begin
                rdata[STAT_BUSY]     = (state_q != IDLE);
                rdata[STAT_RX_VALID] = rx_valid;
                rdata[STAT_OVERRUN]  = overrun;
                rdata[STAT_ABORT]    = abort_err;
            end
            ADDR_CTRL: begin
                rdata[CTRL_IRQ_EN]   = irq_en;
`ifdef SPI_ENGINE_LOOPBACK_EN
                rdata[CTRL_LOOPBACK] = loopback;
`endif
            end
            default: rdata = '0;
        endcase
    end

    assign avs.readdata = rdata;

endmodule
